probe_capture_core: RTL

PROBE_CAPTURE_CORE -- requirements
Module: probe_capture_core

---
 rtl/probe_capture_core.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/probe_capture_core.sv
// Trigger-based probe capture buffer with pre-trigger history and valid/ready readout.
// Optional feature: define PROBE_CAPTURE_TRIG_COUNT_EN to add the trig_count occurrence counter.
module probe_capture_core #(
  parameter int PROBE_W  = 32,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PROBE_W-1:0] probe,
  input  logic               arm,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
`ifdef PROBE_CAPTURE_TRIG_COUNT_EN
  input  logic [15:0]        trig_count,
`endif
  output logic               busy,
  output logic               triggered,
  output logic               done,
  input  logic               rd_start,
  output logic [PROBE_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               rd_last
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PRE_LAST = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_N   = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] PRE_OFF  = AW'(PRE_TRIG);
  localparam logic [AW:0]   RD_N     = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEFT_ONE = (AW + 1)'(1);

  logic [2:0]         state;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      cnt;
  logic [AW-1:0]      trig_addr;
  logic [PROBE_W-1:0] mem [DEPTH];

  logic [AW-1:0]      rd_ptr_p0;
  logic [AW:0]        rd_left_p0;
  logic               rd_busy_p0;

  logic capturing;
  logic start_cap;
  logic match;
  logic fire;
  logic rd_go;
  logic rd_load;

  function automatic logic trig_hit(input logic [PROBE_W-1:0] p,
                                    input logic [PROBE_W-1:0] v,
                                    input logic [PROBE_W-1:0] m);
    return ((p ^ v) & m) == '0;
  endfunction

  assign capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign start_cap = arm && ((state == S_IDLE) || (state == S_DONE)) && !rd_busy_p0;
  assign match     = (state == S_ARMED) && trig_hit(probe, trig_value, trig_mask);
  assign busy      = capturing;
  assign done      = (state == S_DONE);

`ifdef PROBE_CAPTURE_TRIG_COUNT_EN
  // Earlier matches are recorded as ordinary samples; only match number trig_count+1 fires.
  logic [15:0] match_cnt;

  assign fire = match && (match_cnt == trig_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (start_cap) begin
      match_cnt <= '0;
    end else if (match && !fire) begin
      match_cnt <= match_cnt + 16'd1;
    end
  end
`else
  assign fire = match;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      triggered <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_cap) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            triggered <= 1'b0;
            state     <= (PRE_TRIG == 0) ? S_ARMED : S_PRE;
          end
        end
        S_PRE: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          cnt    <= cnt + PTR_ONE;
          if (cnt == PRE_LAST) state <= S_ARMED;
        end
        S_ARMED: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (fire) begin
            triggered <= 1'b1;
            cnt       <= POST_N;
            state     <= (POST_N == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          cnt    <= cnt - PTR_ONE;
          if (cnt == PTR_ONE) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fire) trig_addr <= wr_ptr;
  end

  // Buffer contents survive reset; done gates whether they are readable.
  always_ff @(posedge clk) begin
    if (capturing) mem[wr_ptr] <= probe;
  end

  assign rd_go   = (state == S_DONE) && rd_start && !arm && !rd_busy_p0;
  assign rd_load = rd_busy_p0 && (rd_left_p0 != '0) && (!rd_valid || rd_ready);

  // Stage p0: start address and remaining count; output stage: registered buffer read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_busy_p0 <= 1'b0;
      rd_ptr_p0  <= '0;
      rd_left_p0 <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
    end else if (rd_go) begin
      rd_busy_p0 <= 1'b1;
      rd_ptr_p0  <= trig_addr - PRE_OFF;
      rd_left_p0 <= RD_N;
    end else if (rd_load) begin
      rd_data    <= mem[rd_ptr_p0];
      rd_valid   <= 1'b1;
      rd_last    <= (rd_left_p0 == LEFT_ONE);
      rd_ptr_p0  <= rd_ptr_p0 + PTR_ONE;
      rd_left_p0 <= rd_left_p0 - LEFT_ONE;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (rd_last) rd_busy_p0 <= 1'b0;
    end
  end

endmodule
